// File: rtl/apb_master.sv
// apb_master -- APB4 requester.
//
// Turns a valid/ready command stream into APB4 SETUP/ACCESS transfers and
// returns one completion per command on a valid/ready response channel.
// It inserts wait states while PREADY is low and forwards PSLVERR. Reads
// always drive PSTRB=0. A transfer is aborted after TIMEOUT_CYCLES stalled
// ACCESS cycles. A value of 0 disables the timeout.
//
// Handshake rule (both channels): a beat transfers at the rising PCLK edge
// where valid && ready are both high. Once valid is high, the payload holds
// steady until that edge. ready may depend combinationally on the other side.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata/strb/prot   command payload
//   rsp_valid/rsp_ready  response handshake (rsp_* registered)
//   rsp_rdata/err/timeout            response payload
//   PSEL..PPROT          APB requester outputs (registered)
//   PRDATA/PREADY/PSLVERR            APB completer inputs
//   dbg_state            current FSM state (IDLE=0, SETUP=1, ACCESS=2)

`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH (`APB_DATA_WIDTH/8)
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_master #(
  parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
  parameter int STRB_WIDTH     = `APB_STRB_WIDTH,
  parameter int PROT_WIDTH     = `APB_PROT_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [PROT_WIDTH-1:0] cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic [PROT_WIDTH-1:0] PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic          accept;
  logic          xfer_done;
  logic          xfer_abort;

  // A held, unconsumed response blocks the next command. Consuming it on
  // the same edge frees the slot, so a new command can be taken then.
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // PREADY wins over the timeout on the final allowed cycle.
        if (PREADY) begin
          xfer_done = 1'b1;
          state_d   = IDLE;
        end else if (TO_EN && (wait_q == TO_LIMIT)) begin
          xfer_abort = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts stalled ACCESS cycles. It stays at zero outside ACCESS, so it
  // starts from zero each time ACCESS is entered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                wait_q <= '0;
    else if (state_q != ACCESS)                  wait_q <= '0;
    else if (TO_EN && !PREADY && !xfer_abort)    wait_q <= wait_q + 1'b1;
  end

  // The APB control outputs follow the next state, so they are registered.
  // They still show SETUP/ACCESS during the matching cycles. Payload
  // registers load only on accept. They hold through the transfer and
  // afterwards.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PPROT   <= '0;
    end else begin
      PSEL    <= (state_d != IDLE);
      PENABLE <= (state_d == ACCESS);
      if (accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
        PPROT  <= cmd_prot;
        PSTRB  <= cmd_write ? cmd_strb : '0;
      end
    end
  end

  // A completion can only occur while the response slot is empty. The
  // command was accepted only after the slot was free. So load and consume
  // never compete.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (xfer_done) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= PWRITE ? '0 : PRDATA;
      rsp_err     <= PSLVERR;
      rsp_timeout <= 1'b0;
    end else if (xfer_abort) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master -- self-checking bench for apb_master.
// A behavioural APB completer with adjustable wait states, errors and a
// stuck mode sits on the bus. A word-array reference model plus the
// latency rule give the expected value of every response.

module tb_apb_master;

  localparam int AW = 32, DW = 32, SW = 4, PW = 3, TO = 16;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [PW-1:0] cmd_prot = '0;
  logic          cmd_ready;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [SW-1:0] PSTRB;
  logic [PW-1:0] PPROT;
  logic [1:0]    dbg_state;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
               .PROT_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural completer ----------------
  int          wait_cfg = 0;
  bit          err_cfg  = 1'b0;
  bit          stuck    = 1'b0;
  int          acc_cnt  = 0;
  logic [31:0] mem [16] = '{default: 32'h0};

  // Outside the completing cycle, PSLVERR and PRDATA carry junk.
  assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= wait_cfg);
  assign PSLVERR = PREADY ? err_cfg : 1'b1;
  assign PRDATA  = (PREADY && !PWRITE) ? mem[PADDR[5:2]] : 32'hBAD0_BAD0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PREADY && PWRITE && !err_cfg)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [32:0] exp_q[$];   // {err, rdata}
  logic [32:0] got_q[$];

  function automatic void model_write(int idx, logic [31:0] d, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  // ---------------- bus monitor (records, tests compare) ----------------
  int  mon_setup_len = 0, mon_access_len = 0, mon_viol = 0;
  bit  mon_unstable = 1'b0;
  logic [3:0] mon_strb = '0;
  logic [AW+DW+SW+PW:0] snap;
  bit  prev_setup = 1'b0, prev_access = 1'b0;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PSEL && !PENABLE) begin
        if (prev_setup) mon_setup_len++;
        else begin
          mon_setup_len = 1; mon_access_len = 0; mon_unstable = 1'b0;
          mon_strb = PSTRB; snap = {PADDR, PWDATA, PSTRB, PPROT, PWRITE};
        end
      end else if (PSEL && PENABLE) begin
        if (!prev_setup && !prev_access) mon_viol++;
        mon_access_len++;
        if ({PADDR, PWDATA, PSTRB, PPROT, PWRITE} !== snap) mon_unstable = 1'b1;
      end else if (PENABLE) mon_viol++;
      prev_setup  = PSEL && !PENABLE;
      prev_access = PSEL && PENABLE;
    end else begin
      prev_setup = 1'b0; prev_access = 1'b0;
    end
  end

  bit collect_en = 1'b0;
  always @(negedge PCLK)
    if (collect_en && rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_rdata});

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    cmd_strb = s; cmd_prot = p;
  endtask

  // Call this at a negedge with the command driven. It returns at the
  // negedge after the accepting edge, with cyc equal to the accept count.
  task automatic wait_accept(output int acc_cyc);
    int g = 0;
    #1;
    while (!cmd_ready && g < 60) begin @(negedge PCLK); #1; g++; end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: cmd_ready got 0 want 1 within 60 cycles");
      @(negedge PCLK);
      acc_cyc = cyc;
      return;
    end
    @(posedge PCLK);
    @(negedge PCLK);
    acc_cyc = cyc;
  endtask

  // Latency is counted from the accepting edge to the edge that consumes
  // the response: accept at edge N with rsp first visible after N+2 gives 3.
  task automatic wait_rsp(input int acc_cyc, output int lat, output logic [31:0] rd,
                          output bit er, output bit to);
    int g = 0;
    while (!rsp_valid && g < 60) begin @(negedge PCLK); g++; end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait: rsp_valid got 0 want 1 within 60 cycles");
      lat = -1; rd = 32'hx; er = 1'bx; to = 1'bx;
      return;
    end
    lat = cyc - acc_cyc + 1; rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    PRESETn = 1'b0;
    drive_cmd(1'b1, 32'h40, 32'h1234_5678, 4'hF, 3'd5);
    repeat (2) @(negedge PCLK);
    #1;
    n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_bad++; $display("FAIL rst_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin n_bad++; $display("FAIL rst_rsp: got %b want 000", {rsp_valid, rsp_err, rsp_timeout}); end
    n_cmp++; if (PADDR !== 32'h0) begin n_bad++; $display("FAIL rst_paddr: got %h want 0", PADDR); end
    n_cmp++; if (PWDATA !== 32'h0) begin n_bad++; $display("FAIL rst_pwdata: got %h want 0", PWDATA); end
    n_cmp++; if ({PSTRB, PPROT} !== 7'h0) begin n_bad++; $display("FAIL rst_strb_prot: got %h want 0", {PSTRB, PPROT}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    cmd_valid = 1'b0;
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_cmp++; if ({PSEL, PADDR} !== 33'h0) begin n_bad++; $display("FAIL rst_no_accept: got PSEL=%b PADDR=%h want 0/0", PSEL, PADDR); end
  endtask

  task automatic test_write_read();
    int ac, lat; logic [31:0] rd; bit er, to;
    drive_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd2);
    wait_accept(ac); cmd_valid = 1'b0;
    n_cmp++; if ({PSEL, PENABLE} !== 2'b10) begin n_bad++; $display("FAIL wr_setup_phase: got %b want 10", {PSEL, PENABLE}); end
    wait_rsp(ac, lat, rd, er, to);
    model_write(4, 32'hDEAD_BEEF, 4'hF);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if ({er, to, rd} !== 34'h0) begin n_bad++; $display("FAIL wr_rsp: got err=%b to=%b rd=%h want 0/0/0", er, to, rd); end
    n_cmp++; if (mon_setup_len !== 1 || mon_access_len !== 1) begin n_bad++; $display("FAIL wr_phases: got setup=%0d access=%0d want 1/1", mon_setup_len, mon_access_len); end
    n_cmp++; if (mon_strb !== 4'hF) begin n_bad++; $display("FAIL wr_pstrb: got %h want f", mon_strb); end
    // read back with strobes set: PSTRB must still be 0 on the bus
    drive_cmd(1'b0, 32'h10, 32'h0, 4'hF, 3'd0);
    wait_accept(ac); cmd_valid = 1'b0;
    wait_rsp(ac, lat, rd, er, to);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== ref_mem[4]) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, ref_mem[4]); end
    n_cmp++; if ({er, to} !== 2'b00) begin n_bad++; $display("FAIL rd_err: got %b want 00", {er, to}); end
    n_cmp++; if (mon_strb !== 4'h0) begin n_bad++; $display("FAIL rd_pstrb: got %h want 0", mon_strb); end
  endtask

  task automatic test_wait_err();
    int ac, lat; logic [31:0] rd; bit er, to;
    wait_cfg = 3; err_cfg = 1'b1;
    drive_cmd(1'b1, 32'h24, $urandom(), 4'($urandom_range(1, 15)), 3'd1);
    wait_accept(ac); cmd_valid = 1'b0;
    wait_rsp(ac, lat, rd, er, to);
    wait_cfg = 0; err_cfg = 1'b0;
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL werr_latency: got %0d want 6", lat); end
    n_cmp++; if ({er, to, rd} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL werr_rsp: got err=%b to=%b rd=%h want 1/0/0", er, to, rd); end
    n_cmp++; if (mon_access_len !== 4 || mon_unstable) begin n_bad++; $display("FAIL werr_hold: got access=%0d unstable=%b want 4/0", mon_access_len, mon_unstable); end
  endtask

  task automatic test_timeout();
    int ac, lat; logic [31:0] rd; bit er, to;
    stuck = 1'b1;
    drive_cmd(1'b0, 32'h08, 32'h0, 4'h0, 3'd0);
    wait_accept(ac); cmd_valid = 1'b0;
    wait_rsp(ac, lat, rd, er, to);
    stuck = 1'b0;
    n_cmp++; if (lat !== TO + 3) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", lat, TO + 3); end
    n_cmp++; if ({er, to, rd} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL to_rsp: got err=%b to=%b rd=%h want 1/1/0", er, to, rd); end
    n_cmp++; if (mon_access_len !== TO + 1) begin n_bad++; $display("FAIL to_access_len: got %0d want %0d", mon_access_len, TO + 1); end
    n_cmp++; if ({PSEL, PENABLE} !== 2'b00) begin n_bad++; $display("FAIL to_bus_idle: got %b want 00", {PSEL, PENABLE}); end
  endtask

  task automatic test_random();
    int ac, lat, w, idx; logic [31:0] rd, d; bit er, to, wr, e; logic [3:0] s;
    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15); d = $urandom();
      s = 4'($urandom_range(0, 15)); w = $urandom_range(0, 4); e = ($urandom_range(0, 3) == 0);
      wait_cfg = w; err_cfg = e;
      exp_q.push_back({e, wr ? 32'h0 : ref_mem[idx]});
      if (wr && !e) model_write(idx, d, s);
      drive_cmd(wr, 32'(idx * 4), d, s, 3'($urandom_range(0, 7)));
      wait_accept(ac); cmd_valid = 1'b0;
      wait_rsp(ac, lat, rd, er, to);
      n_cmp++; if ({er, rd} !== exp_q[0]) begin n_bad++; $display("FAIL rnd_rsp[%0d]: got %h want %h", i, {er, rd}, exp_q[0]); end
      void'(exp_q.pop_front());
      n_cmp++; if (lat !== 3 + w || to !== 1'b0) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d/to=%b want %0d/0", i, lat, to, 3 + w); end
      n_cmp++; if (mon_strb !== (wr ? s : 4'h0) || mon_access_len !== w + 1 || mon_unstable) begin
        n_bad++; $display("FAIL rnd_bus[%0d]: got strb=%h access=%0d unstable=%b want %h/%0d/0", i, mon_strb, mon_access_len, mon_unstable, wr ? s : 4'h0, w + 1);
      end
    end
    wait_cfg = 0; err_cfg = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ac, prev_ac, idx; logic [31:0] d; bit wr; logic [3:0] s;
    exp_q.delete(); got_q.delete();
    rsp_ready = 1'b1; collect_en = 1'b1;
    prev_ac = -1;
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15);
      d = $urandom(); s = 4'($urandom_range(0, 15));
      exp_q.push_back({1'b0, wr ? 32'h0 : ref_mem[idx]});
      if (wr) model_write(idx, d, s);
      drive_cmd(wr, 32'(idx * 4), d, s, 3'd0);
      wait_accept(ac);
      if (i > 0) begin
        n_cmp++; if (ac - prev_ac !== 3) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, ac - prev_ac); end
      end
      prev_ac = ac;
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge PCLK);
    rsp_ready = 1'b0; collect_en = 1'b0;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL b2b_rsp: got %h want %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_stall();
    int ac, lat, g; logic [31:0] rd, d; bit er, to; logic [33:0] held;
    d = $urandom();
    model_write(12, d, 4'hF);
    rsp_ready = 1'b0;
    drive_cmd(1'b1, 32'h30, d, 4'hF, 3'd3);
    wait_accept(ac);
    drive_cmd(1'b0, 32'h30, 32'h0, 4'h0, 3'd0);
    g = 0;
    while (!rsp_valid && g < 60) begin @(negedge PCLK); g++; end
    held = {rsp_err, rsp_timeout, rsp_rdata};
    n_cmp++; if ({rsp_valid, held} !== {1'b1, 34'h0}) begin n_bad++; $display("FAIL stall_first_rsp: got %b/%h want 1/0", rsp_valid, held); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({cmd_ready, PSEL, rsp_valid} !== 3'b001 || {rsp_err, rsp_timeout, rsp_rdata} !== held) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got rdy=%b psel=%b vld=%b rsp=%h want 0/0/1/%h", i, cmd_ready, PSEL, rsp_valid, {rsp_err, rsp_timeout, rsp_rdata}, held);
      end
      @(negedge PCLK);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got cmd_ready=%b want 1", cmd_ready); end
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0; cmd_valid = 1'b0; ac = cyc;
    n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL stall_second_setup: got %b want 100", {PSEL, PENABLE, rsp_valid}); end
    wait_rsp(ac, lat, rd, er, to);
    n_cmp++; if (lat !== 3 || {er, to} !== 2'b00 || rd !== ref_mem[12]) begin n_bad++; $display("FAIL stall_second_rsp: got lat=%0d err=%b rd=%h want 3/0/%h", lat, er, rd, ref_mem[12]); end
  endtask

  task automatic test_reset_mid();
    int ac, lat; logic [31:0] rd, d; bit er, to;
    stuck = 1'b1;
    drive_cmd(1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 3'd0);
    wait_accept(ac); cmd_valid = 1'b0;
    @(negedge PCLK);
    n_cmp++; if ({PSEL, PENABLE} !== 2'b11) begin n_bad++; $display("FAIL rmid_in_access: got %b want 11", {PSEL, PENABLE}); end
    #2 PRESETn = 1'b0;
    #1;
    n_cmp++; if ({PSEL, PENABLE} !== 2'b00) begin n_bad++; $display("FAIL rmid_async_drop: got %b want 00", {PSEL, PENABLE}); end
    stuck = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_cmp++; if ({rsp_valid, PSEL} !== 2'b00) begin n_bad++; $display("FAIL rmid_no_rsp: got vld=%b psel=%b want 0/0", rsp_valid, PSEL); end
    d = $urandom();
    model_write(14, d, 4'hF);
    drive_cmd(1'b1, 32'h38, d, 4'hF, 3'd0);
    wait_accept(ac); cmd_valid = 1'b0;
    wait_rsp(ac, lat, rd, er, to);
    n_cmp++; if (lat !== 3 || {er, to, rd} !== 34'h0) begin n_bad++; $display("FAIL rmid_write: got lat=%0d err=%b to=%b rd=%h want 3/0/0/0", lat, er, to, rd); end
    drive_cmd(1'b0, 32'h38, 32'h0, 4'h0, 3'd0);
    wait_accept(ac); cmd_valid = 1'b0;
    wait_rsp(ac, lat, rd, er, to);
    n_cmp++; if (rd !== ref_mem[14] || er !== 1'b0) begin n_bad++; $display("FAIL rmid_readback: got %h err=%b want %h/0", rd, er, ref_mem[14]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge PCLK);
    test_reset();
    test_write_read();
    test_wait_err();
    test_timeout();
    test_random();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    repeat (2) @(negedge PCLK);
    n_cmp++; if (mon_viol !== 0) begin n_bad++; $display("FAIL protocol_order: got %0d violations want 0", mon_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
